// File: rtl/vic_vect_arbiter.sv
// Vectored-IRQ priority arbiter and in-service sequencer for the VIC.
// Define VIC_NESTING_EN for nested preemption; the default build is single level.
module vic_vect_arbiter #(
  parameter int NSLOT = 16,
  parameter int INTW  = 32,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INTW-1:0]    irq_status,
  input  logic [NSLOT-1:0]   slot_en,
  input  logic [NSLOT*5-1:0] slot_src,
  input  logic [NSLOT*AW-1:0] slot_addr,
  input  logic [AW-1:0]      def_addr,
  input  logic               vaddr_rd,
  input  logic               vaddr_wr,
  output logic               nirq,
  output logic [AW-1:0]      vect_addr_out,
  output logic [NSLOT:0]     in_service
);

  localparam int LW = $clog2(NSLOT + 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state;
  logic [LW-1:0]   l_reg;

  logic [31:0]     irq_ext;
  logic [31:0]     claimed;
  logic [NSLOT-1:0] hit;
  logic            slot_found;
  logic            cur_found;
  logic            nonvec;
  logic            req;
  logic            pend;
  logic [LW-1:0]   req_lvl;
  logic [LW-1:0]   cur_lvl;
  logic [LW-1:0]   sel_lvl;
  logic [AW-1:0]   sel_addr;
  logic            ack;
  logic [NSLOT:0]  is_clr;
  logic [NSLOT:0]  is_set;
  logic [NSLOT:0]  is_next;

  always_comb begin
    irq_ext             = '0;
    irq_ext[INTW-1:0]   = irq_status;
    claimed             = '0;
    hit                 = '0;
    slot_found          = 1'b0;
    req_lvl             = LW'(NSLOT);
    for (int unsigned i = 0; i < NSLOT; i++) begin
      hit[i] = slot_en[i] & irq_ext[slot_src[5*i +: 5]];
      if (slot_en[i])
        claimed[slot_src[5*i +: 5]] = 1'b1;
      if (hit[i] && !slot_found) begin
        req_lvl    = LW'(i);
        slot_found = 1'b1;
      end
    end
    nonvec = |(irq_ext & ~claimed);
    req    = slot_found | nonvec;

    cur_found = 1'b0;
    cur_lvl   = LW'(NSLOT + 1);
    for (int unsigned i = 0; i <= NSLOT; i++) begin
      if (in_service[i] && !cur_found) begin
        cur_lvl   = LW'(i);
        cur_found = 1'b1;
      end
    end

`ifdef VIC_NESTING_EN
    pend = req && (req_lvl < cur_lvl);
`else
    pend = req && (in_service == '0);
`endif

    sel_lvl  = req ? req_lvl : cur_lvl;
    sel_addr = def_addr;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (sel_lvl == LW'(i))
        sel_addr = slot_addr[AW*i +: AW];
    end
  end

  // EOI clear is applied before the acknowledge set; the set uses the level
  // registered with the address the CPU is reading this cycle.
  always_comb begin
    ack    = vaddr_rd & (state == ST_PEND);
    is_clr = vaddr_wr ? (in_service & (in_service - (NSLOT+1)'(1))) : in_service;
    is_set = (NSLOT+1)'(1) << l_reg;
`ifdef VIC_NESTING_EN
    is_next = ack ? (is_clr | is_set) : is_clr;
`else
    is_next = (ack && (is_clr == '0)) ? is_set : is_clr;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      vect_addr_out <= '0;
      l_reg         <= '0;
      in_service    <= '0;
    end else begin
      if (pend)
        state <= ST_PEND;
      else if (in_service != '0)
        state <= ST_SERVICE;
      else
        state <= ST_IDLE;
      vect_addr_out <= sel_addr;
      l_reg         <= sel_lvl;
      in_service    <= is_next;
    end
  end

  assign nirq = (state != ST_PEND);

endmodule

// File: doc/vic_vect_arbiter.md
# vic_vect_arbiter

Vectored-IRQ priority arbiter and service sequencer for the vectored interrupt controller. It takes the masked IRQ status and the 16 vector slots (control and address registers) from the register block. It resolves the highest-priority pending source, drives `nVICIRQ` and the vector address, and tracks in-service state from the CPU's vector-address read (acknowledge) to its vector-address write (end of interrupt). It sits between the controller's register file and the core's IRQ input.

## Interface
Parameters:
- `NSLOT`, 16, number of vectored slots; slot 0 has the highest priority.
- `INTW`, 32, number of interrupt sources.
- `AW`, 32, vector address width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `irq_status`  in  INTW  raw interrupts AND IntEnable AND NOT IntSelect; level-sensitive.
- `slot_en`  in  NSLOT  VectCntl enable bit, one per slot.
- `slot_src`  in  NSLOT*5  VectCntl source number per slot; slot i occupies bits [5i+4:5i].
- `slot_addr`  in  NSLOT*AW  VectAddr per slot; slot i occupies bits [AW*i+AW-1:AW*i].
- `def_addr`  in  AW  DefVectAddr.
- `vaddr_rd`  in  1  one-cycle pulse; CPU read of VICVectAddr (acknowledge).
- `vaddr_wr`  in  1  one-cycle pulse; CPU write of VICVectAddr (end of interrupt).
- `nirq`  out  1  IRQ request to the core, active-low, registered.
- `vect_addr_out`  out  AW  current vector address, registered.
- `in_service`  out  NSLOT+1  in-service mask; bit NSLOT is the default (non-vectored) level.

## Operation
- Slot hit: `hit[i] = slot_en[i] & irq_status[slot_src[i]]`.
- Winner: the lowest index i with `hit[i]`.
- Non-vectored pending: any `irq_status` bit not claimed by an enabled slot. This is priority level NSLOT, which is the lowest.
- Duplicate sources in several slots: the lowest-index slot wins.
- Request level L: the winner index. If no slot hits, L = NSLOT when non-vectored is pending, otherwise none.
- Current level C: the index of the lowest set bit of `in_service`, or NSLOT+1 when `in_service` is 0.
- States:
  - IDLE: `in_service` = 0 and no request; `nirq` = 1.
  - PEND: a request exists with L < C; `nirq` = 0.
  - SERVICE: `in_service` ≠ 0 and no qualifying request; `nirq` = 1.
- `vect_addr_out` selection:
  - When a request exists: `slot_addr[L]`, or `def_addr` if L = NSLOT.
  - Otherwise: the address of level C, or `def_addr` when C = NSLOT+1.
- `vaddr_rd` with `nirq` = 0 (acknowledge):
  - Sets `in_service[L_reg]`, where L_reg is the level registered alongside the `vect_addr_out` value present in that cycle.
  - The CPU therefore always gets the address that matches the level marked in service.
- `vaddr_rd` with `nirq` = 1: no state change.
- `vaddr_wr` (end of interrupt): clears the lowest set bit of `in_service`. Ignored when `in_service` = 0.
- `vaddr_rd` and `vaddr_wr` in the same cycle: the clear is applied first, then the set, evaluated against the pre-clear L_reg.
- A source deasserting while in PEND: the request is withdrawn. `nirq` returns to 1 on the next edge. No in-service bit is set.
- Changes to `slot_*` while in service: do not alter `in_service`. The new values take effect at the next arbitration.

## Timing
- Arbitration is combinational. `nirq`, `vect_addr_out` and L_reg are registered, giving 1-cycle latency from `irq_status`/`slot_*` to outputs.
- An acknowledge updates `in_service` at the edge ending the `vaddr_rd` cycle. `nirq` reflects the new C one cycle later; the CPU sees `nirq` = 1 no later than the second edge after acknowledge.
- End of interrupt: the same one-edge update. Re-arbitration against the new C is visible on `nirq` at the following edge.
- Reset (asynchronous, at any time, including mid-service): `nirq` = 1, `vect_addr_out` = 0, `in_service` = 0, L_reg = 0, state IDLE. Sources still pending after reset deasserts reassert `nirq` 1 cycle later.

## Configuration
- `VIC_NESTING_EN` defined:
  - Nested preemption as described above. Any request with L < C asserts `nirq` while in SERVICE, and `in_service` may hold several bits.
- `VIC_NESTING_EN` undefined:
  - Single level. The PEND condition becomes "request exists AND `in_service` = 0".
  - `in_service` holds at most one bit. End of interrupt clears it.
  - Requests arriving during SERVICE wait, with `nirq` = 1, until end of interrupt.

## Test plan
- Slot 3 routes source 7, slot 5 routes source 2; raise both → `nirq` = 0 after 1 cycle with `vect_addr_out` = `slot_addr[3]`; acknowledge → `in_service` = 0x0008, `nirq` = 1.
- Raise only unclaimed source 20 → `vect_addr_out` = `def_addr`; acknowledge → `in_service` bit 16 set; end of interrupt → `in_service` = 0.
- Nesting on: slot 5 in service, raise slot 2's source → `nirq` = 0 with `slot_addr[2]`; acknowledge → `in_service` = 0x0024; end of interrupt → 0x0020; end of interrupt → 0.
- Nesting off: same stimulus → `nirq` stays 1 until the first end of interrupt, then asserts with `slot_addr[2]`.
- Raise a source, drop it before acknowledge → `nirq` returns to 1, `in_service` = 0; `vaddr_rd` then → no change. `vaddr_wr` with `in_service` = 0 → ignored.
- Assert `rst` low mid-SERVICE with `in_service` = 0x0024 → immediately `nirq` = 1, `in_service` = 0, `vect_addr_out` = 0.
